// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide engine for the HI/LO register pair.
// Radix-4 Booth multiply (WIDTH/2 steps), non-restoring divide (WIDTH steps + fix-up).
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]      step;
  logic [2*WIDTH-1:0] mcand, acc, pp, prod_next;
  logic [WIDTH:0]     mplier;
  logic [WIDTH+1:0]   prem, prem_shift, prem_next;
  logic [WIDTH-1:0]   quot, quot_next, dvs;
  logic [WIDTH-1:0]   rem_mag, quot_fix, rem_fix;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_q, neg_r;
  logic               accept, b_zero;

  assign busy   = (state == MUL) || (state == DIV) || (state == FIX);
  assign done   = (state == DONE);
  assign accept = start && !busy;
  assign b_zero = (b == '0);
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (!op)        state_next = MUL;
          else if (b_zero) state_next = DONE;
          else            state_next = DIV;
        end else begin
          state_next = IDLE;
        end
      end
      MUL: if (step == MUL_LAST) state_next = DONE;
      DIV: if (step == DIV_LAST) state_next = FIX;
      FIX: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Booth recoding of {q[2i+1], q[2i], q[2i-1]}; mcand already carries the 2i shift.
  always_comb begin
    pp = '0;
    unique case (mplier[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  assign prod_next = acc + pp;

  // Non-restoring step: the partial remainder sign selects add or subtract of the divisor.
  assign prem_shift = {prem[WIDTH:0], quot[WIDTH-1]};
  assign prem_next  = prem[WIDTH+1] ? prem_shift + {2'b00, dvs}
                                    : prem_shift - {2'b00, dvs};
  assign quot_next  = {quot[WIDTH-2:0], ~prem_next[WIDTH+1]};

  assign rem_mag  = prem[WIDTH-1:0] + (prem[WIDTH+1] ? dvs : '0);
  assign quot_fix = neg_q ? -quot : quot;
  assign rem_fix  = neg_r ? -rem_mag : rem_mag;

  // NOTE: every datapath register, including the result pair, is cleared by the async reset.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      step        <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      prem        <= '0;
      quot        <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            step        <= '0;
            mcand       <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier      <= {b, 1'b0};
            acc         <= '0;
            prem        <= '0;
            quot        <= a_mag;
            dvs         <= b_mag;
            neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r       <= a[WIDTH-1];
            div_by_zero <= op && b_zero;
            if (op && b_zero) begin
              hi <= a;
              lo <= '1;
            end
          end
        end
        MUL: begin
          acc    <= prod_next;
          mcand  <= mcand << 2;
          mplier <= mplier >> 2;
          step   <= step + CW'(1);
          if (step == MUL_LAST) {hi, lo} <= prod_next;
        end
        DIV: begin
          prem <= prem_next;
          quot <= quot_next;
          step <= step + CW'(1);
        end
        FIX: begin
          hi <= rem_fix;
          lo <= quot_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_muldiv_seq;

  logic        clock, clear, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain signed 64-bit math.
  function automatic void model_calc(input logic o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl,
                                     output logic rz);
    longint p, q, r;
    p = longint'($signed(x)) * longint'($signed(y));
    rz = 1'b0;
    if (!o) begin
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == 32'd0) begin
      rh = x;
      rl = 32'hFFFF_FFFF;
      rz = 1'b1;
    end else begin
      q  = longint'($signed(x)) / longint'($signed(y));
      r  = longint'($signed(x)) % longint'($signed(y));
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  // Cycle model: an accepted op produces its result a fixed number of edges later.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi, p_lo;
  logic        p_dbz;
  int          remaining = 0;

  always @(posedge clear) begin
    m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
    m_hi = '0; m_lo = '0; remaining = 0;
  end

  always @(posedge clock) begin
    if (!clear) begin
      logic nd;
      nd = 1'b0;
      if (m_busy) begin
        remaining--;
        if (remaining == 0) begin
          m_busy = 1'b0;
          nd     = 1'b1;
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_dbz  = p_dbz;
        end
      end else if (start) begin
        model_calc(op, a, b, p_hi, p_lo, p_dbz);
        m_dbz = 1'b0;
        if (op && b == 32'd0) begin
          nd    = 1'b1;
          m_hi  = p_hi;
          m_lo  = p_lo;
          m_dbz = 1'b1;
        end else begin
          m_busy    = 1'b1;
          remaining = op ? 33 : 16;
        end
      end
      m_done = nd;
    end
  end

  always @(negedge clock) begin
    if (!clear) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("div_by_zero", div_by_zero, m_dbz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Presents a request, lets the accept edge pass, then scrambles the inputs.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    if (!(o && y == 32'd0)) check("dbz_cleared_at_accept", div_by_zero, 1'b0);
  endtask

  // Counts edges after the accept edge until done is seen.
  task automatic wait_done(input int lat, input logic [31:0] eh, input logic [31:0] el,
                           input logic ez);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clock); n++; #1;
    end
    check("done_seen", done, 1'b1);
    check("latency", 64'(n), 64'(lat));
    check("hi_expected", hi, eh);
    check("lo_expected", lo, el);
    check("dbz_expected", div_by_zero, ez);
  endtask

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int lat,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez);
    @(negedge clock);
    issue(o, x, y);
    wait_done(lat, eh, el, ez);
    @(posedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_dbz", div_by_zero, 1'b0);
    repeat (2) @(negedge clock);
    clear = 1'b0;

    // Multiply: result appears on the 16th edge after accept.
    run_op(1'b0, 32'd7,        32'hFFFF_FFFD, 16, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 16, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 16, 32'hC000_0000, 32'h8000_0000, 1'b0);

    // Divide: 32 steps plus one fix-up edge.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b1, 32'd7,        32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0);
    run_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0010, 33, 32'h0000_000F, 32'h07FF_FFFF, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // Divide by zero: the accept edge enters DONE directly.
    run_op(1'b1, 32'd5, 32'd0, 0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op(1'b0, 32'd2, 32'd3, 16, 32'd0, 32'd6, 1'b0);

    // Start with op=1 at step 5 of a multiply is ignored.
    @(negedge clock);
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (5) @(posedge clock);
    #1; start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd0;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(10, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(posedge clock);

    // Back-to-back: a new request held during the DONE cycle is accepted.
    @(negedge clock);
    issue(1'b1, 32'd100, 32'd7);
    wait_done(33, 32'd2, 32'd14, 1'b0);
    issue(1'b0, 32'd3, 32'd4);
    wait_done(16, 32'd0, 32'd12, 1'b0);
    @(posedge clock);

    // Clear in the middle of a multiply wipes outputs without a clock.
    @(negedge clock);
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (7) @(posedge clock);
    #2; clear = 1'b1;
    #1;
    check("clr_busy", busy, 1'b0);
    check("clr_done", done, 1'b0);
    check("clr_hi", hi, 32'h0);
    check("clr_lo", lo, 32'h0);
    check("clr_dbz", div_by_zero, 1'b0);
    @(negedge clock);
    clear = 1'b0;
    run_op(1'b0, 32'd9, 32'd9, 16, 32'd0, 32'd81, 1'b0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
